// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared pipeline constants: default widths and the MEM-stage
//               state encodings used by the pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int c_DATA_WIDTH            = 64;
    localparam int c_REGFILE_ADDRESS_WIDTH = 5;
    localparam int c_DMEM_ADDR_WIDTH       = 8;
    localparam int c_TIMEOUT_CYCLES        = 16;

    localparam int                   c_STATE_W  = 1;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles spent waiting for dmem_ack; flags the cycle on
//               whose closing edge the count reaches TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int                 c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry is flagged one count early so the exit edge is the one that
    // would have taken the counter to TIMEOUT_CYCLES-1.
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 2);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage: passes ALU ops through in one cycle and
//               performs one blocking data-memory access with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH            = c_DATA_WIDTH,
    parameter int REGFILE_ADDRESS_WIDTH = c_REGFILE_ADDRESS_WIDTH,
    parameter int DMEM_ADDR_WIDTH       = c_DMEM_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES        = c_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            alu_result_in,
    input  logic [DATA_WIDTH-1:0]            store_data_in,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] rd_in,
    input  logic                             mem_read_in,
    input  logic                             mem_write_in,
    input  logic                             mem_to_reg_in,
    output logic                             dmem_req,
    output logic                             dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0]       dmem_addr,
    output logic [DATA_WIDTH-1:0]            dmem_wdata,
    input  logic                             dmem_ack,
    input  logic [DATA_WIDTH-1:0]            dmem_rdata,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            mem_read_data_out,
    output logic [DATA_WIDTH-1:0]            reg_data_out,
    output logic [REGFILE_ADDRESS_WIDTH-1:0] rd_out,
    output logic                             mem_to_reg_out,
    output logic                             stall,
    output logic                             err
);

    logic [c_STATE_W-1:0]             r_state;
    logic [REGFILE_ADDRESS_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]            r_reg_data;
    logic                             r_mem_to_reg;
    logic                             r_is_store;

    logic w_in_ready;
    logic w_accept;
    logic w_mem_op;
    logic w_expired;

    assign w_in_ready = (r_state == c_ST_IDLE);
    assign w_accept   = w_in_ready && in_valid;
    assign w_mem_op   = mem_read_in || mem_write_in;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_accept),
        .run     (r_state == c_ST_WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= c_ST_IDLE;
            r_rd              <= '0;
            r_reg_data        <= '0;
            r_mem_to_reg      <= 1'b0;
            r_is_store        <= 1'b0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            out_valid         <= 1'b0;
            mem_read_data_out <= '0;
            reg_data_out      <= '0;
            rd_out            <= '0;
            mem_to_reg_out    <= 1'b0;
            stall             <= 1'b0;
            err               <= 1'b0;
        end else begin
            out_valid         <= 1'b0;
            mem_read_data_out <= '0;
            reg_data_out      <= '0;
            rd_out            <= '0;
            mem_to_reg_out    <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_mem_op) begin
                            r_state      <= c_ST_WAIT;
                            stall        <= 1'b1;
                            dmem_req     <= 1'b1;
                            dmem_we      <= mem_write_in;
                            dmem_addr    <= alu_result_in[DMEM_ADDR_WIDTH-1:0];
                            dmem_wdata   <= store_data_in;
                            r_rd         <= rd_in;
                            r_reg_data   <= alu_result_in;
                            r_mem_to_reg <= mem_to_reg_in;
                            // A read+write request is executed as a store.
                            r_is_store   <= mem_write_in;
                            if (mem_read_in && mem_write_in) begin
                                err <= 1'b1;
                            end
                        end else begin
                            out_valid      <= 1'b1;
                            reg_data_out   <= alu_result_in;
                            rd_out         <= rd_in;
                            mem_to_reg_out <= mem_to_reg_in;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (dmem_ack || w_expired) begin
                        r_state    <= c_ST_IDLE;
                        stall      <= 1'b0;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        out_valid  <= 1'b1;
                        if (dmem_ack) begin
                            reg_data_out <= r_reg_data;
                            if (!r_is_store) begin
                                mem_read_data_out <= dmem_rdata;
                                rd_out            <= r_rd;
                                mem_to_reg_out    <= r_mem_to_reg;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Scoreboard testbench for mem_access_stage: directed scenarios
//               followed by randomized ALU/load/store traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int c_TO = 16;

    typedef struct {
        int          cyc;
        logic [63:0] reg_d;
        logic [63:0] mem_d;
        logic [4:0]  rd;
        logic        m2r;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [63:0] alu_result_in;
    logic [63:0] store_data_in;
    logic [4:0]  rd_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        out_valid;
    logic [63:0] mem_read_data_out;
    logic [63:0] reg_data_out;
    logic [4:0]  rd_out;
    logic        mem_to_reg_out;
    logic        stall;
    logic        err;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Expected stage/memory-port state after the next rising edge.
    logic        m_stall = 0, m_req = 0, m_we = 0, m_err = 0;
    logic [7:0]  m_addr  = 0;
    logic [63:0] m_wdata = 0;

    // Next op held on the inputs while the stage is stalled.
    logic        hold_en = 0;
    logic [63:0] hold_alu = 0;
    logic [4:0]  hold_rd = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_WIDTH            (64),
        .REGFILE_ADDRESS_WIDTH (5),
        .DMEM_ADDR_WIDTH       (8),
        .TIMEOUT_CYCLES        (c_TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .alu_result_in     (alu_result_in),
        .store_data_in     (store_data_in),
        .rd_in             (rd_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .out_valid         (out_valid),
        .mem_read_data_out (mem_read_data_out),
        .reg_data_out      (reg_data_out),
        .rd_out            (rd_out),
        .mem_to_reg_out    (mem_to_reg_out),
        .stall             (stall),
        .err               (err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Monitor: per-cycle port state plus scoreboard pops on out_valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            check("stall", stall, m_stall);
            check("dmem_req", dmem_req, m_req);
            check("err", err, m_err);
            if (m_req) begin
                check("dmem_we", dmem_we, m_we);
                check("dmem_addr", dmem_addr, m_addr);
                check("dmem_wdata", dmem_wdata, m_wdata);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("reg_data_out", reg_data_out, e.reg_d);
                    check("mem_read_data_out", mem_read_data_out, e.mem_d);
                    check("rd_out", rd_out, e.rd);
                    check("mem_to_reg_out", mem_to_reg_out, e.m2r);
                end
            end else begin
                check("idle_outputs", mem_read_data_out | reg_data_out | 64'(rd_out) | 64'(mem_to_reg_out), 0);
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    check("missing_out_valid", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive_junk();
        in_valid      = 1'($urandom_range(0, 1));
        mem_read_in   = 1'($urandom_range(0, 1));
        mem_write_in  = 1'($urandom_range(0, 1));
        alu_result_in = {$urandom, $urandom};
        store_data_in = {$urandom, $urandom};
        rd_in         = 5'($urandom);
        mem_to_reg_in = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_junk();
        in_valid   = 1'b0;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = {$urandom, $urandom};
    endtask

    // Issue one op; d = WAIT cycles before the ack cycle, to = never ack.
    task automatic run_op(input bit rd_i, input bit wr_i, input logic [63:0] alu,
                          input logic [63:0] sd, input logic [4:0] rd, input bit m2r,
                          input int d, input bit to, input logic [63:0] rdat);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid      = 1'b1;
        mem_read_in   = rd_i;
        mem_write_in  = wr_i;
        alu_result_in = alu;
        store_data_in = sd;
        rd_in         = rd;
        mem_to_reg_in = m2r;
        dmem_ack      = 1'($urandom_range(0, 1));
        dmem_rdata    = {$urandom, $urandom};
        if (!rd_i && !wr_i) begin
            e.cyc = cyc + 1; e.reg_d = alu; e.mem_d = 0; e.rd = rd; e.m2r = m2r;
            q.push_back(e);
            return;
        end
        n = to ? c_TO - 1 : d + 1;
        e.cyc = cyc + 1 + n;
        if (to) begin
            e.reg_d = 0; e.mem_d = 0; e.rd = 0; e.m2r = 0;
        end else begin
            e.reg_d = alu;
            e.mem_d = wr_i ? 64'd0 : rdat;
            e.rd    = wr_i ? 5'd0 : rd;
            e.m2r   = wr_i ? 1'b0 : m2r;
        end
        q.push_back(e);
        m_stall = 1; m_req = 1; m_we = wr_i; m_addr = alu[7:0]; m_wdata = sd;
        if (rd_i && wr_i) m_err = 1;
        for (int w = 1; w <= n; w++) begin
            @(negedge clk);
            drive_junk();
            if (hold_en) begin
                in_valid = 1; mem_read_in = 0; mem_write_in = 0;
                alu_result_in = hold_alu; rd_in = hold_rd; mem_to_reg_in = 1;
            end
            dmem_ack   = !to && (w == n);
            dmem_rdata = dmem_ack ? rdat : {$urandom, $urandom};
            if (w == n) begin
                m_stall = 0; m_req = 0;
                if (to) m_err = 1;
            end
        end
    endtask

    initial begin
        int          kind;
        logic [63:0] a;
        reset_n = 1'b0;
        in_valid = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
        alu_result_in = 0; store_data_in = 0; rd_in = 0; dmem_ack = 0; dmem_rdata = 0;
        #3;
        check("rst_dmem_req", dmem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_cycle();

        run_op(0, 0, 64'h1234, 0, 5'd7, 1, 0, 0, 0);
        run_op(1, 0, 64'h40, 0, 5'd3, 1, 2, 0, 64'hDEADBEEF);
        run_op(0, 1, 64'h80, 64'hAA55, 5'd9, 1, 0, 0, 0);
        run_op(1, 0, 64'h10, 0, 5'd4, 1, 0, 1, 0);
        run_op(0, 0, 64'h55, 0, 5'd12, 0, 0, 0, 0);
        hold_en = 1; hold_alu = 64'h777; hold_rd = 5'd11;
        run_op(1, 0, 64'h22, 0, 5'd6, 1, 3, 0, 64'h1111);
        run_op(0, 0, 64'h777, 0, 5'd11, 1, 0, 0, 0);
        hold_en = 0;
        idle_cycle();

        // Reset while a load is outstanding: no completion may follow.
        @(negedge clk);
        in_valid = 1; mem_read_in = 1; mem_write_in = 0;
        alu_result_in = 64'h33; store_data_in = 64'h5; rd_in = 5'd2; dmem_ack = 0;
        m_stall = 1; m_req = 1; m_we = 0; m_addr = 8'h33; m_wdata = 64'h5;
        @(negedge clk);
        in_valid = 0; dmem_ack = 0;
        #2;
        reset_n = 1'b0;
        m_stall = 0; m_req = 0; m_err = 0;
        #1;
        check("async_rst_dmem_req", dmem_req, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle_cycle();

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            a    = {$urandom, $urandom};
            run_op(kind >= 4 && kind != 7 && kind != 8, kind >= 7, a, {$urandom, $urandom},
                   5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                   $urandom_range(0, 19) == 0, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        repeat (20) idle_cycle();
        @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
